// File: rtl/alux_sequencer_if.sv
// ----------------------------------------------------------------------------
// alux_sequencer_if
// Purpose : bundles the three handshakes around the ALUX sequencer
//           (command in, ALUX drive/return, result out).
// Signals :
//   cmd_valid / cmd_ready          command handshake
//   cmd_opr[3:0], cmd_a/cmd_b[63:0] opcode and complex operands {Re,Im}
//   alu_start, alu_opr, alu_inA/B   drive to the ALUX
//   alu_done, alu_outAB             ALUX completion and result
//   res_valid / res_ready           result handshake
//   res_data, res_opr, res_err      result, echoed opcode, error flag
// Modports:
//   master : environment side (issues commands, acts as ALUX, takes results)
//   slave  : sequencer side
// ----------------------------------------------------------------------------
interface alux_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opr;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;

  logic        alu_start;
  logic [3:0]  alu_opr;
  logic [63:0] alu_inA;
  logic [63:0] alu_inB;
  logic        alu_done;
  logic [63:0] alu_outAB;

  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_opr;
  logic        res_err;

  modport master (
    output cmd_valid, cmd_opr, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_start, alu_opr, alu_inA, alu_inB,
    output alu_done, alu_outAB,
    input  res_valid, res_data, res_opr, res_err,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_opr, cmd_a, cmd_b,
    output cmd_ready,
    output alu_start, alu_opr, alu_inA, alu_inB,
    input  alu_done, alu_outAB,
    output res_valid, res_data, res_opr, res_err,
    input  res_ready
  );
endinterface

// File: rtl/alux_sequencer.sv
// ----------------------------------------------------------------------------
// alux_sequencer
// Purpose : queues complex-arithmetic commands in a small FIFO and feeds them
//           one at a time to an ALUX unit, returning each result (or an error
//           for an illegal opcode) through a valid/ready result port.
// Parameters:
//   DEPTH   command FIFO entries (power of two, >= 2)
//   TIMEOUT WAIT cycles allowed before an abort (only with the macro below)
// Ports:
//   clock   master clock, rising edge
//   reset   asynchronous, active-low reset
//   bus     alux_sequencer_if.slave (command, ALUX and result handshakes)
//   busy    high while the FSM is not IDLE or the FIFO holds commands
// Build option:
//   ALUX_SEQ_TIMEOUT_EN  when defined, an ALUX operation that does not
//                        complete within TIMEOUT WAIT cycles is abandoned and
//                        reported with res_err=1, res_data=0.
// ----------------------------------------------------------------------------
module alux_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic            clock,
  input  logic            reset,
  alux_sequencer_if.slave bus,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Elaboration-time guard on the parameter ranges the design relies on
  // (pointer wrap needs a power-of-two depth).
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
    $error("alux_sequencer: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_timeoutCheck
    $error("alux_sequencer: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [3:0]    r_oprMem [DEPTH];
  logic [63:0]   r_aMem   [DEPTH];
  logic [63:0]   r_bMem   [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_headOpr;
  logic [63:0]   w_headA;
  logic [63:0]   w_headB;
  logic          w_headLegal;

  logic          r_aluStart;
  logic [3:0]    r_aluOpr;
  logic [63:0]   r_aluInA;
  logic [63:0]   r_aluInB;
  logic          r_resValid;
  logic [63:0]   r_resData;
  logic [3:0]    r_resOpr;
  logic          r_resErr;

  logic          w_aluStartNext;
  logic [3:0]    w_aluOprNext;
  logic [63:0]   w_aluInANext;
  logic [63:0]   w_aluInBNext;
  logic          w_resValidNext;
  logic [63:0]   w_resDataNext;
  logic [3:0]    w_resOprNext;
  logic          w_resErrNext;

`ifdef ALUX_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] r_waitCnt;
  logic [TW-1:0] w_waitCntNext;
`endif

  // FIFO status comes from the registered count only, so a full FIFO does
  // not advertise space in the same cycle the head is being popped. The
  // reset term forces cmd_ready low the instant reset is asserted.
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign bus.cmd_ready = reset && !w_full;
  assign w_push        = bus.cmd_valid && bus.cmd_ready;

  assign w_headOpr = r_oprMem[r_rdPtr];
  assign w_headA   = r_aMem[r_rdPtr];
  assign w_headB   = r_bMem[r_rdPtr];

  assign busy = (r_state != IDLE) || !w_empty;

  assign bus.alu_start = r_aluStart;
  assign bus.alu_opr   = r_aluOpr;
  assign bus.alu_inA   = r_aluInA;
  assign bus.alu_inB   = r_aluInB;
  assign bus.res_valid = r_resValid;
  assign bus.res_data  = r_resData;
  assign bus.res_opr   = r_resOpr;
  assign bus.res_err   = r_resErr;

  // Opcode decode for the FIFO head: only these nine opcodes are sent to
  // the ALUX, anything else is answered directly with an error result.
  always_comb begin
    case (w_headOpr)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA: w_headLegal = 1'b1;
      default:                                             w_headLegal = 1'b0;
    endcase
  end

  // Command storage. The payload array carries no reset; a flush only needs
  // the pointers and count cleared, which the pointer block does.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_oprMem[r_wrPtr] <= bus.cmd_opr;
      r_aMem[r_wrPtr]   <= bus.cmd_a;
      r_bMem[r_wrPtr]   <= bus.cmd_b;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and next-output logic. The FIFO head stays in place while the
  // ALUX works on it and is popped only when its result is captured, which
  // keeps exactly one operation outstanding. alu_done is looked at only in
  // WAIT; the issued operands are held untouched until the next issue.
  always_comb begin
    w_stateNext    = r_state;
    w_pop          = 1'b0;
    w_aluStartNext = 1'b0;
    w_aluOprNext   = r_aluOpr;
    w_aluInANext   = r_aluInA;
    w_aluInBNext   = r_aluInB;
    w_resValidNext = r_resValid;
    w_resDataNext  = r_resData;
    w_resOprNext   = r_resOpr;
    w_resErrNext   = r_resErr;
`ifdef ALUX_SEQ_TIMEOUT_EN
    w_waitCntNext  = r_waitCnt;
`endif
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_headLegal) begin
            w_stateNext    = ISSUE;
            w_aluStartNext = 1'b1;
            w_aluOprNext   = w_headOpr;
            w_aluInANext   = w_headA;
            w_aluInBNext   = w_headB;
          end else begin
            w_stateNext    = HOLD;
            w_pop          = 1'b1;
            w_resValidNext = 1'b1;
            w_resDataNext  = '0;
            w_resOprNext   = w_headOpr;
            w_resErrNext   = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_stateNext = WAIT;
`ifdef ALUX_SEQ_TIMEOUT_EN
        w_waitCntNext = '0;
`endif
      end
      WAIT: begin
        if (bus.alu_done) begin
          w_stateNext    = HOLD;
          w_pop          = 1'b1;
          w_resValidNext = 1'b1;
          w_resDataNext  = bus.alu_outAB;
          w_resOprNext   = r_aluOpr;
          w_resErrNext   = 1'b0;
        end
`ifdef ALUX_SEQ_TIMEOUT_EN
        else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
          w_stateNext    = HOLD;
          w_pop          = 1'b1;
          w_resValidNext = 1'b1;
          w_resDataNext  = '0;
          w_resOprNext   = r_aluOpr;
          w_resErrNext   = 1'b1;
        end else begin
          w_waitCntNext = r_waitCnt + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (bus.res_ready) begin
          w_stateNext    = IDLE;
          w_resValidNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset abandons any ALUX operation in
  // flight: the FSM returns to IDLE and no result is ever produced for it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_aluStart <= 1'b0;
      r_aluOpr   <= '0;
      r_aluInA   <= '0;
      r_aluInB   <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resOpr   <= '0;
      r_resErr   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_aluStart <= w_aluStartNext;
      r_aluOpr   <= w_aluOprNext;
      r_aluInA   <= w_aluInANext;
      r_aluInB   <= w_aluInBNext;
      r_resValid <= w_resValidNext;
      r_resData  <= w_resDataNext;
      r_resOpr   <= w_resOprNext;
      r_resErr   <= w_resErrNext;
    end
  end

`ifdef ALUX_SEQ_TIMEOUT_EN
  // Cycles spent in WAIT for the current operation; cleared on WAIT entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= w_waitCntNext;
    end
  end
`endif

endmodule

// File: tb/tb_alux_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alux_sequencer
// Purpose : self-checking bench for alux_sequencer. A transaction-level model
//           (command queue plus expected result/issue values) predicts every
//           output each cycle; directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_alux_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;

  typedef struct packed {
    logic [3:0]  opr;
    logic [63:0] a;
    logic [63:0] b;
  } cmd_t;

  logic clock = 1'b0;
  logic reset;
  logic busy;

  alux_sequencer_if bus ();

  alux_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int vecCount  = 0;
  int missCount = 0;
  int doneDelay = 0;
  int forceReq  = 0;

  // Stand-in ALUX behaviour: opcode 2 is a component-wise complex add, every
  // other opcode produces a distinctive mix of the operands.
  function automatic logic [63:0] aluFn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 4'h2) begin
      return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
    end
    return a ^ {b[31:0], b[63:32]} ^ {60'd0, op};
  endfunction

  function automatic bit isLegal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the sequencer: the queue holds accepted commands, the e*
  // variables hold what the outputs must show after each clock edge.
  cmd_t        cmdQ [$];
  bit          eStart;
  bit          eWaiting;
  bit          eValid;
  logic [3:0]  eAluOpr;
  logic [63:0] eInA;
  logic [63:0] eInB;
  logic [63:0] eResData;
  logic [3:0]  eResOpr;
  bit          eResErr;
  int          eWaitCycles;

  // Model update on every clock edge from the inputs the DUT is sampling.
  always @(posedge clock or negedge reset) begin
    bit   pushOk;
    cmd_t inCmd;
    if (!reset) begin
      cmdQ.delete();
      eStart      = 0;
      eWaiting    = 0;
      eValid      = 0;
      eWaitCycles = 0;
    end else begin
      pushOk    = bus.cmd_valid && (cmdQ.size() < DEPTH);
      inCmd.opr = bus.cmd_opr;
      inCmd.a   = bus.cmd_a;
      inCmd.b   = bus.cmd_b;
      if (eValid) begin
        if (bus.res_ready) eValid = 0;
      end else if (eStart) begin
        eStart      = 0;
        eWaiting    = 1;
        eWaitCycles = 0;
      end else if (eWaiting) begin
        if (bus.alu_done) begin
          eWaiting = 0;
          eValid   = 1;
          eResData = bus.alu_outAB;
          eResOpr  = eAluOpr;
          eResErr  = 0;
          void'(cmdQ.pop_front());
        end
`ifdef ALUX_SEQ_TIMEOUT_EN
        else begin
          eWaitCycles++;
          if (eWaitCycles == TIMEOUT) begin
            eWaiting = 0;
            eValid   = 1;
            eResData = '0;
            eResOpr  = eAluOpr;
            eResErr  = 1;
            void'(cmdQ.pop_front());
          end
        end
`endif
      end else if (cmdQ.size() != 0) begin
        if (isLegal(cmdQ[0].opr)) begin
          eStart  = 1;
          eAluOpr = cmdQ[0].opr;
          eInA    = cmdQ[0].a;
          eInB    = cmdQ[0].b;
        end else begin
          eValid   = 1;
          eResData = '0;
          eResOpr  = cmdQ[0].opr;
          eResErr  = 1;
          void'(cmdQ.pop_front());
        end
      end
      if (pushOk) cmdQ.push_back(inCmd);
    end
  end

  // Compare process: every mid-cycle while out of reset, all outputs are
  // checked against the model; payloads only while they are meaningful.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      checkOutput("cmd_ready", bus.cmd_ready, cmdQ.size() < DEPTH);
      checkOutput("busy", busy, eStart || eWaiting || eValid || (cmdQ.size() != 0));
      checkOutput("alu_start", bus.alu_start, eStart);
      if (eStart || eWaiting) begin
        checkOutput("alu_opr", bus.alu_opr, eAluOpr);
        checkOutput("alu_inA", bus.alu_inA, eInA);
        checkOutput("alu_inB", bus.alu_inB, eInB);
      end
      checkOutput("res_valid", bus.res_valid, eValid);
      if (eValid) begin
        checkOutput("res_data", bus.res_data, eResData);
        checkOutput("res_opr", bus.res_opr, eResOpr);
        checkOutput("res_err", bus.res_err, eResErr);
      end
    end
  end

  // ALUX stand-in: answers doneDelay cycles after seeing alu_start (never
  // when doneDelay is 0), or immediately when the bench requests a pulse.
  initial begin
    bit opOpen;
    int waitCnt;
    int forceSeen;
    opOpen        = 0;
    waitCnt       = 0;
    forceSeen     = 0;
    bus.alu_done  = 1'b0;
    bus.alu_outAB = '0;
    forever begin
      @(negedge clock);
      bus.alu_done  = 1'b0;
      bus.alu_outAB = 64'hBAD0_BAD0_BAD0_BAD0;
      if (reset !== 1'b1) begin
        opOpen = 0;
      end else if (bus.alu_start) begin
        opOpen  = 1;
        waitCnt = 0;
      end else if (opOpen) begin
        waitCnt++;
      end
      if (forceReq != forceSeen) begin
        forceSeen     = forceReq;
        bus.alu_done  = 1'b1;
        bus.alu_outAB = aluFn(bus.alu_opr, bus.alu_inA, bus.alu_inB);
        opOpen        = 0;
      end else if (opOpen && doneDelay > 0 && waitCnt >= doneDelay) begin
        bus.alu_done  = 1'b1;
        bus.alu_outAB = aluFn(bus.alu_opr, bus.alu_inA, bus.alu_inB);
        opOpen        = 0;
      end
    end
  end

  // Offer one command starting at a falling edge; returns at the falling
  // edge right after the accepting clock edge.
  task automatic applyStimulus(input cmd_t c, input int budget);
    bus.cmd_valid = 1'b1;
    bus.cmd_opr   = c.opr;
    bus.cmd_a     = c.a;
    bus.cmd_b     = c.b;
    while (!bus.cmd_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) checkOutput("cmd accept timeout", bus.cmd_ready, 1);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitAluStart(input int budget);
    while (!bus.alu_start && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    checkOutput("wait alu_start", bus.alu_start, 1);
  endtask

  task automatic waitResValid(input int budget);
    while (!bus.res_valid && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    checkOutput("wait res_valid", bus.res_valid, 1);
  endtask

  task automatic waitIdle(input int budget);
    while (busy && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    checkOutput("return to idle", busy, 0);
  endtask

  // Hard stop in case a scenario wedges despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", missCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    cmd_t        c;
    cmd_t        t3Cmds [5];
    logic [63:0] expRes [5];
    int          got;
    int          budget;

    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opr   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("reset cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset alu_start", bus.alu_start, 0);
    checkOutput("reset res_valid", bus.res_valid, 0);
    checkOutput("reset res_err", bus.res_err, 0);
    #2 reset = 1'b1;
    #1 checkOutput("cmd_ready after release", bus.cmd_ready, 1);
    @(negedge clock);

    // Single complex add with hand-computed latency and result
    $display("[TB] single command");
    bus.res_ready = 1'b1;
    doneDelay     = 2;
    c = '{opr: 4'h2, a: 64'h00000003_00000004, b: 64'h00000001_00000002};
    applyStimulus(c, 20);
    checkOutput("t1 no start at N+1", bus.alu_start, 0);
    @(negedge clock);
    checkOutput("t1 start at N+2", bus.alu_start, 1);
    checkOutput("t1 alu_opr", bus.alu_opr, 64'h2);
    checkOutput("t1 alu_inA", bus.alu_inA, 64'h00000003_00000004);
    checkOutput("t1 alu_inB", bus.alu_inB, 64'h00000001_00000002);
    repeat (2) @(negedge clock);
    checkOutput("t1 res_valid before done", bus.res_valid, 0);
    @(negedge clock);
    checkOutput("t1 res_valid", bus.res_valid, 1);
    checkOutput("t1 res_data", bus.res_data, 64'h00000004_00000006);
    checkOutput("t1 res_err", bus.res_err, 0);
    checkOutput("t1 res_opr", bus.res_opr, 64'h2);
    waitIdle(20);

    // Illegal opcode answered without touching the ALUX
    $display("[TB] illegal opcode");
    c = '{opr: 4'h5, a: 64'h1111_2222_3333_4444, b: 64'h5555_6666_7777_8888};
    applyStimulus(c, 20);
    checkOutput("t2 res_valid at N+1", bus.res_valid, 0);
    @(negedge clock);
    checkOutput("t2 res_valid at N+2", bus.res_valid, 1);
    checkOutput("t2 res_data", bus.res_data, 0);
    checkOutput("t2 res_err", bus.res_err, 1);
    checkOutput("t2 res_opr", bus.res_opr, 64'h5);
    checkOutput("t2 alu_start", bus.alu_start, 0);
    waitIdle(20);

    // FIFO fill, back-pressure on results, in-order drain
    $display("[TB] fill and hold");
    for (int i = 0; i < 5; i++) begin
      t3Cmds[i].opr = 4'(i);
      t3Cmds[i].a   = {32'(i + 1), 32'(16 * i + 7)};
      t3Cmds[i].b   = {32'(100 + i), 32'(3 * i + 1)};
      expRes[i]     = aluFn(t3Cmds[i].opr, t3Cmds[i].a, t3Cmds[i].b);
    end
    bus.res_ready = 1'b0;
    doneDelay     = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus(t3Cmds[i], 200);
      end
      begin
        repeat (12) @(negedge clock);
        checkOutput("t3 full cmd_ready", bus.cmd_ready, 0);
        checkOutput("t3 full busy", busy, 1);
        doneDelay = 2;
        waitResValid(20);
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          checkOutput("t3 hold res_valid", bus.res_valid, 1);
          checkOutput("t3 hold res_data", bus.res_data, expRes[0]);
          checkOutput("t3 hold no start", bus.alu_start, 0);
        end
        checkOutput("t3 refilled cmd_ready", bus.cmd_ready, 0);
      end
    join
    bus.res_ready = 1'b1;
    got    = 0;
    budget = 300;
    while (got < 5 && budget > 0) begin
      if (bus.res_valid) begin
        checkOutput("t3 result order", bus.res_data, expRes[got]);
        got++;
      end
      @(negedge clock);
      budget--;
    end
    checkOutput("t3 results drained", 64'(got), 64'd5);
    waitIdle(20);

    // Reset in the middle of WAIT, stray alu_done afterwards
    $display("[TB] reset during WAIT");
    doneDelay = 0;
    c = '{opr: 4'h3, a: 64'hA5A5_0000_0000_5A5A, b: 64'h0F0F_0F0F_F0F0_F0F0};
    applyStimulus(c, 20);
    waitAluStart(20);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("t4 async cmd_ready", bus.cmd_ready, 0);
    checkOutput("t4 async busy", busy, 0);
    checkOutput("t4 async alu_opr", bus.alu_opr, 0);
    checkOutput("t4 async alu_inA", bus.alu_inA, 0);
    checkOutput("t4 async res_valid", bus.res_valid, 0);
    checkOutput("t4 async res_data", bus.res_data, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    forceReq++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("t4 no res_valid", bus.res_valid, 0);
      checkOutput("t4 busy", busy, 0);
      checkOutput("t4 cmd_ready", bus.cmd_ready, 1);
    end

    // Missing alu_done
    doneDelay = 0;
    c = '{opr: 4'h8, a: 64'h0123_4567_89AB_CDEF, b: 64'hFEDC_BA98_7654_3210};
    applyStimulus(c, 20);
    waitAluStart(20);
`ifdef ALUX_SEQ_TIMEOUT_EN
    $display("[TB] WAIT timeout");
    repeat (TIMEOUT) @(negedge clock);
    checkOutput("t5 no abort yet", bus.res_valid, 0);
    @(negedge clock);
    checkOutput("t5 abort res_valid", bus.res_valid, 1);
    checkOutput("t5 abort res_err", bus.res_err, 1);
    checkOutput("t5 abort res_data", bus.res_data, 0);
    waitIdle(20);
`else
    $display("[TB] WAIT without done");
    repeat (200) @(negedge clock);
    checkOutput("t5 still waiting res_valid", bus.res_valid, 0);
    checkOutput("t5 still waiting busy", busy, 1);
    checkOutput("t5 still waiting start", bus.alu_start, 0);
    forceReq++;
    waitResValid(10);
    checkOutput("t5 late res_err", bus.res_err, 0);
    checkOutput("t5 late res_opr", bus.res_opr, 64'h8);
    checkOutput("t5 late res_data", bus.res_data, aluFn(c.opr, c.a, c.b));
    waitIdle(20);
`endif

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/alux_sequencer.md
ALUX_SEQUENCER -- requirements
Module: alux_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 63, maximum WAIT cycles before abort (used only with ALUX_SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clock  in  1  master clock, posedge active.
REQ-004 SHALL have port reset  in  1  master reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 SHALL have ports cmd_opr in 4, cmd_a in 64, cmd_b in 64: opcode and complex operands ({Re[63:32], Im[31:0]}).
REQ-007 SHALL have ports alu_start out 1, alu_opr out 4, alu_inA out 64, alu_inB out 64: drive to ALUX start/opr/inA/inB.
REQ-008 SHALL have ports alu_done in 1, alu_outAB in 64: ALUX completion and result.
REQ-009 SHALL have ports res_valid out 1, res_ready in 1: result handshake.
REQ-010 SHALL have ports res_data out 64, res_opr out 4, res_err out 1: result, echoed opcode, error flag.
REQ-011 SHALL have port busy out 1: high when FSM is not IDLE or FIFO is non-empty.

Function
REQ-012 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = !full, computed from registered count (no same-cycle pop credit when full).
REQ-013 SHALL store accepted commands in-order in a DEPTH-entry FIFO with wrapping read/write pointers; occupancy range 0..DEPTH.
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE: FIFO empty -> stay; head opcode legal -> ISSUE; head opcode illegal -> HOLD with res_data=0, res_err=1, pop.
REQ-016 Legal opcodes SHALL be 0x0,0x1,0x2,0x3,0x4,0x6,0x8,0x9,0xA; all others illegal.
REQ-017 ISSUE: alu_start high exactly one cycle; alu_opr/inA/inB registered from FIFO head; -> WAIT.
REQ-018 alu_opr/alu_inA/alu_inB SHALL hold stable from ISSUE until WAIT exits.
REQ-019 WAIT: on alu_done=1, register alu_outAB into res_data, res_err=0, res_opr=issued opcode, pop FIFO, -> HOLD.
REQ-020 alu_done SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-021 HOLD: res_valid=1 and res_data/res_opr/res_err stable until res_ready; on handshake res_valid falls next cycle, -> IDLE.
REQ-022 Latency: command accepted at cycle N into empty idle FIFO SHALL raise alu_start at cycle N+2; res_valid rises the cycle after alu_done.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged (non-full case).
REQ-024 Only one ALUX operation SHALL be outstanding at any time.

Reset
REQ-025 On reset low: FSM -> IDLE, FIFO flushed (pointers, count = 0), all outputs 0 including cmd_ready, immediately and asynchronously.
REQ-026 Reset asserted mid-operation SHALL abandon the outstanding ALUX op; no result emitted for it.
REQ-027 After reset deasserts, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-028 With macro ALUX_SEQ_TIMEOUT_EN defined, a WAIT counter SHALL abort after TIMEOUT cycles without alu_done: res_data=0, res_err=1, pop, -> HOLD; counter clears on WAIT entry.
REQ-029 Without ALUX_SEQ_TIMEOUT_EN, WAIT SHALL persist indefinitely and res_err SHALL be set only for illegal opcodes; TIMEOUT unused.

Verification
REQ-030 Single cmd opr=0x2, a=0x00000003_00000004, b=0x00000001_00000002 -> alu_start at N+2; model done 2 cycles later with outAB=0x00000004_00000006 -> res_valid, res_data=0x00000004_00000006, res_err=0.
REQ-031 Push 5 cmds back-to-back with DEPTH=4, no done -> cmd_ready=0 after 4th accept; 5th held until first pop; results emerge in push order.
REQ-032 cmd opr=0x5 -> no alu_start; res_valid with res_data=0, res_err=1, res_opr=0x5.
REQ-033 res_ready=0 for 10 cycles in HOLD -> res_valid/res_data stable, no new alu_start, FIFO keeps accepting until full.
REQ-034 Reset low during WAIT, then alu_done pulses after release -> no res_valid, busy=0, cmd_ready=1.
REQ-035 With ALUX_SEQ_TIMEOUT_EN, TIMEOUT=63, never assert alu_done -> res_err=1, res_data=0 at 63 cycles after WAIT entry; without macro -> still in WAIT after 200 cycles.
